// File: rtl/johnson_pkg.sv
// Shared types and Johnson-code helpers for the johnson_seq_ctrl slice.
// Helpers work on a zero-extended 32-bit word plus the active stage count.
package johnson_pkg;

    localparam int unsigned JC_MAX_W = 32;

    typedef logic [JC_MAX_W-1:0] jc_word_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    // Shift right, feeding the inverted LSB into the top stage.
    function automatic jc_word_t jc_next_fwd(input jc_word_t jc, input int unsigned w);
        jc_word_t inv_lsb;
        inv_lsb = jc_word_t'(~jc[0]);
        return (jc >> 1) | (inv_lsb << (w - 1));
    endfunction

    // Shift left, feeding the inverted MSB into stage 0; mask keeps bits above w clear.
    function automatic jc_word_t jc_next_rev(input jc_word_t jc, input int unsigned w);
        jc_word_t mask;
        jc_word_t msb;
        mask = (w >= JC_MAX_W) ? '1 : ((jc_word_t'(1) << w) - jc_word_t'(1));
        msb  = (jc >> (w - 1)) & jc_word_t'(1);
        return ((jc << 1) & mask) | (msb ^ jc_word_t'(1));
    endfunction

    function automatic int unsigned jc_to_index(input jc_word_t jc, input int unsigned w);
        jc_word_t    t;
        int unsigned ones;
        t    = jc;
        ones = 0;
        for (int unsigned i = 0; i < JC_MAX_W; i++) begin
            if (i < w && t[0]) begin
                ones++;
            end
            t = t >> 1;
        end
        return jc[0] ? (w + (w - ones)) : ones;
    endfunction

    // Legal codes have at most one 0/1 boundary between adjacent stages.
    function automatic logic jc_is_legal(input jc_word_t jc, input int unsigned w);
        jc_word_t    t;
        int unsigned edges;
        t     = jc;
        edges = 0;
        for (int unsigned i = 0; i + 1 < JC_MAX_W; i++) begin
            if (i + 1 < w && t[0] != t[1]) begin
                edges++;
            end
            t = t >> 1;
        end
        return edges <= 1;
    endfunction

endpackage

// File: rtl/johnson_phase_decoder.sv
// Combinational decode of a Johnson code into its one-hot phase.
module johnson_phase_decoder
    import johnson_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0]   jc,
    output logic [2*WIDTH-1:0] phase
);

    int unsigned idx;

    always_comb begin
        idx   = jc_to_index(jc_word_t'(jc), WIDTH);
        phase = (2*WIDTH)'(1) << idx;
    end

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Command-driven stepper for a WIDTH-stage Johnson counter with pause/abort.
// Optional illegal-code recovery is built when JC_ILLEGAL_RECOVERY_EN is defined.
module johnson_seq_ctrl
    import johnson_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [CNT_W-1:0]   cmd_steps,
    input  logic               cmd_dir,
    input  logic               pause,
    input  logic               abort,
    output logic [WIDTH-1:0]   jc_state,
    output logic [2*WIDTH-1:0] phase,
    output logic               step_pulse,
    output logic               busy,
    output logic               done,
    output logic               err
);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] jc_q, jc_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;
    logic             step_pulse_q, step_pulse_d;
    logic             legal;

`ifdef JC_ILLEGAL_RECOVERY_EN
    logic             err_q, err_d;

    assign legal = jc_is_legal(jc_word_t'(jc_q), WIDTH);
    assign err   = err_q;
`else
    assign legal = 1'b1;
    assign err   = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        jc_d         = jc_q;
        rem_d        = rem_q;
        dir_d        = dir_q;
        step_pulse_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    rem_d   = cmd_steps;
                    dir_d   = cmd_dir;
                    state_d = (cmd_steps == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (pause) begin
                    state_d = ST_PAUSE;
                end else begin
                    jc_d         = dir_q ? WIDTH'(jc_next_rev(jc_word_t'(jc_q), WIDTH))
                                         : WIDTH'(jc_next_fwd(jc_word_t'(jc_q), WIDTH));
                    step_pulse_d = 1'b1;
                    rem_d        = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_PAUSE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (!pause) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef JC_ILLEGAL_RECOVERY_EN
        // Recovery overrides everything, including a step decided above.
        err_d = err_q;
        if (!legal) begin
            jc_d         = '0;
            err_d        = 1'b1;
            step_pulse_d = 1'b0;
            state_d      = ST_IDLE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            jc_q         <= '0;
            rem_q        <= '0;
            dir_q        <= 1'b0;
            step_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            jc_q         <= jc_d;
            rem_q        <= rem_d;
            dir_q        <= dir_d;
            step_pulse_q <= step_pulse_d;
        end
    end

`ifdef JC_ILLEGAL_RECOVERY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

    // Ready is withheld while an illegal code is pending recovery so no command is dropped.
    assign cmd_ready  = (state_q == ST_IDLE) && legal;
    assign busy       = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign done       = (state_q == ST_DONE);
    assign step_pulse = step_pulse_q;
    assign jc_state   = jc_q;

    johnson_phase_decoder #(
        .WIDTH(WIDTH)
    ) u_phase_decoder (
        .jc    (jc_q),
        .phase (phase)
    );

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Self-checking bench for johnson_seq_ctrl (WIDTH=4): command table, directed
// corner sequences and a randomized run against a ring-position model.
module tb_johnson_seq_ctrl;

    localparam int W     = 4;
    localparam int CNT_W = 8;
    localparam int RING  = 2 * W;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_steps = '0;
    logic             cmd_dir = 1'b0;
    logic             pause = 1'b0;
    logic             abort = 1'b0;
    logic [W-1:0]     jc_state;
    logic [RING-1:0]  phase;
    logic             step_pulse;
    logic             busy;
    logic             done;
    logic             err;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: counter is a position on the ring, commands are a countdown.
    int m_p    = 0;
    int m_mode = M_IDLE;
    int m_rem  = 0;
    bit m_dir  = 1'b0;
    bit m_step = 1'b0;
    bit m_acc  = 1'b0;

    johnson_seq_ctrl #(
        .WIDTH (W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_steps  (cmd_steps),
        .cmd_dir    (cmd_dir),
        .pause      (pause),
        .abort      (abort),
        .jc_state   (jc_state),
        .phase      (phase),
        .step_pulse (step_pulse),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Position p: first p stages set from the top, then the ones drain from the top.
    function automatic logic [W-1:0] code_of(input int p);
        logic [31:0] t;
        if (p <= W) t = ((32'd1 << p) - 32'd1) << (W - p);
        else        t = (32'd1 << (RING - p)) - 32'd1;
        return t[W-1:0];
    endfunction

    always @(posedge clk) begin
        m_step = 1'b0;
        m_acc  = 1'b0;
        if (reset) begin
            m_p    = 0;
            m_mode = M_IDLE;
            m_rem  = 0;
            m_dir  = 1'b0;
        end else begin
            case (m_mode)
                M_IDLE: if (cmd_valid) begin
                    m_acc  = 1'b1;
                    m_rem  = int'(cmd_steps);
                    m_dir  = cmd_dir;
                    m_mode = (m_rem == 0) ? M_DONE : M_RUN;
                end
                M_RUN: begin
                    if (abort)      m_mode = M_IDLE;
                    else if (pause) m_mode = M_PAUSE;
                    else begin
                        m_p    = m_dir ? (m_p + RING - 1) % RING : (m_p + 1) % RING;
                        m_step = 1'b1;
                        m_rem  = m_rem - 1;
                        if (m_rem == 0) m_mode = M_DONE;
                    end
                end
                M_PAUSE: begin
                    if (abort)       m_mode = M_IDLE;
                    else if (!pause) m_mode = M_RUN;
                end
                default: m_mode = M_IDLE;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("m_jc",    32'(jc_state),   32'(code_of(m_p)));
        chk("m_phase", 32'(phase),      32'(1) << m_p);
        chk("m_step",  32'(step_pulse), 32'(m_step));
        chk("m_busy",  32'(busy),       32'(m_mode == M_RUN || m_mode == M_PAUSE));
        chk("m_done",  32'(done),       32'(m_mode == M_DONE));
        chk("m_ready", 32'(cmd_ready),  32'(m_mode == M_IDLE));
        chk("m_err",   32'(err),        32'd0);
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, "_jc"},    32'(jc_state),   32'd0);
        chk({nm, "_phase"}, 32'(phase),      32'd1);
        chk({nm, "_ready"}, 32'(cmd_ready),  32'd1);
        chk({nm, "_busy"},  32'(busy),       32'd0);
        chk({nm, "_done"},  32'(done),       32'd0);
        chk({nm, "_step"},  32'(step_pulse), 32'd0);
        chk({nm, "_err"},   32'(err),        32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        cmd_valid = 1'b0; pause = 1'b0; abort = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Returns at the negedge following the accept edge.
    task automatic issue(input int steps, input bit dir);
        cmd_valid = 1'b1;
        cmd_steps = CNT_W'(steps);
        cmd_dir   = dir;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    typedef struct {
        int           steps;
        bit           dir;
        logic [W-1:0] end_jc;
        logic [7:0]   end_phase;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int pulses;
        int dones;
        logic [W-1:0] exp_seq [3];

        vecs[0] = '{3,   1'b0, 4'b1110, 8'h08};
        vecs[1] = '{9,   1'b0, 4'b1000, 8'h02};
        vecs[2] = '{2,   1'b1, 4'b0011, 8'h40};
        vecs[3] = '{8,   1'b0, 4'b0000, 8'h01};
        vecs[4] = '{16,  1'b1, 4'b0000, 8'h01};
        vecs[5] = '{0,   1'b0, 4'b0000, 8'h01};
        vecs[6] = '{255, 1'b0, 4'b0001, 8'h80};
        vecs[7] = '{13,  1'b1, 4'b1110, 8'h08};

        do_reset();
        check_reset_vals("rst");

        // Command table: each entry from reset, count pulses/done over a window.
        for (int v = 0; v < 8; v++) begin
            do_reset();
            issue(vecs[v].steps, vecs[v].dir);
            pulses = 0;
            dones  = 0;
            for (int c = 0; c < vecs[v].steps + 4; c++) begin
                pulses += int'(step_pulse);
                dones  += int'(done);
                @(negedge clk);
            end
            chk($sformatf("tbl%0d_jc", v),     32'(jc_state),  32'(vecs[v].end_jc));
            chk($sformatf("tbl%0d_phase", v),  32'(phase),     32'(vecs[v].end_phase));
            chk($sformatf("tbl%0d_pulses", v), 32'(pulses),    32'(vecs[v].steps));
            chk($sformatf("tbl%0d_dones", v),  32'(dones),     32'd1);
            chk($sformatf("tbl%0d_ready", v),  32'(cmd_ready), 32'd1);
        end

        // Exact cycle timing of a 3-step forward command.
        exp_seq[0] = 4'b1000; exp_seq[1] = 4'b1100; exp_seq[2] = 4'b1110;
        do_reset();
        issue(3, 1'b0);
        chk("t1_acc_jc",   32'(jc_state),   32'd0);
        chk("t1_acc_busy", 32'(busy),       32'd1);
        chk("t1_acc_rdy",  32'(cmd_ready),  32'd0);
        chk("t1_acc_step", 32'(step_pulse), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("t1_jc%0d", i),   32'(jc_state),   32'(exp_seq[i]));
            chk($sformatf("t1_step%0d", i), 32'(step_pulse), 32'd1);
            chk($sformatf("t1_done%0d", i), 32'(done),       32'(i == 2));
        end
        chk("t1_phase", 32'(phase), 32'h08);
        @(negedge clk);
        chk("t1_post_done", 32'(done),       32'd0);
        chk("t1_post_step", 32'(step_pulse), 32'd0);
        chk("t1_post_rdy",  32'(cmd_ready),  32'd1);
        chk("t1_post_jc",   32'(jc_state),   32'(4'b1110));

        // Pause after step 2 of 4: two stall edges, done two cycles later.
        do_reset();
        issue(4, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("t4_jc2", 32'(jc_state), 32'(4'b1100));
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        chk("t4_hold_jc_a",   32'(jc_state),   32'(4'b1100));
        chk("t4_hold_busy_a", 32'(busy),       32'd1);
        chk("t4_hold_step_a", 32'(step_pulse), 32'd0);
        @(negedge clk);
        chk("t4_hold_jc_b",   32'(jc_state),   32'(4'b1100));
        chk("t4_hold_busy_b", 32'(busy),       32'd1);
        chk("t4_hold_done_b", 32'(done),       32'd0);
        @(negedge clk);
        chk("t4_jc3",   32'(jc_state), 32'(4'b1110));
        chk("t4_done3", 32'(done),     32'd0);
        @(negedge clk);
        chk("t4_jc4",   32'(jc_state), 32'(4'b1111));
        chk("t4_done4", 32'(done),     32'd1);

        // Abort after step 2 of 5, then a zero-step command.
        do_reset();
        issue(5, 1'b0);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t5_jc",   32'(jc_state),  32'(4'b1100));
        chk("t5_rdy",  32'(cmd_ready), 32'd1);
        chk("t5_busy", 32'(busy),      32'd0);
        chk("t5_done", 32'(done),      32'd0);
        @(negedge clk);
        chk("t5_done_late", 32'(done), 32'd0);
        issue(0, 1'b0);
        chk("t5_z_done", 32'(done),       32'd1);
        chk("t5_z_step", 32'(step_pulse), 32'd0);
        chk("t5_z_jc",   32'(jc_state),   32'(4'b1100));
        @(negedge clk);
        chk("t5_z_done_end", 32'(done),      32'd0);
        chk("t5_z_rdy_end",  32'(cmd_ready), 32'd1);

        // Reset mid-run.
        do_reset();
        issue(9, 1'b1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("t6");
        reset = 1'b0;

`ifdef JC_ILLEGAL_RECOVERY_EN
        do_reset();
        issue(20, 1'b0);
        @(negedge clk);
        force dut.jc_q = 4'b1010;
        #1 release dut.jc_q;
        @(negedge clk);
        chk("ill_jc",   32'(jc_state), 32'd0);
        chk("ill_err",  32'(err),      32'd1);
        chk("ill_busy", 32'(busy),     32'd0);
        @(negedge clk);
        chk("ill_err_sticky", 32'(err), 32'd1);
`endif

        // Randomized run against the model; a pending command holds its fields.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            check_model();
            if (!(cmd_valid && !m_acc)) begin
                cmd_valid = ($urandom % 3) == 0;
                cmd_steps = CNT_W'($urandom_range(0, 20));
                cmd_dir   = 1'($urandom % 2);
            end
            pause = ($urandom % 5) == 0;
            abort = ($urandom % 23) == 0;
            reset = ($urandom % 150) == 0;
            @(negedge clk);
        end
        check_model();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
